// File: rtl/rr_mux4.sv
// rr_mux4 -- 4-to-1 collecting multiplexer with round-robin arbitration.
// Gathers beats from four valid/ready source channels into one registered
// output stage. Each held beat carries the 2-bit index of its source.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   [4]        per-channel beat present
//   in_data    [4*WIDTH]  channel i at [i*WIDTH +: WIDTH]
//   in_ready   [4]        one-hot (or zero) accept; combinational
//   out_valid  output register holds a beat
//   out_data   [WIDTH]    held beat data
//   out_sel    [2]        source channel of held beat
//   out_ready  downstream takes the held beat this cycle

// Per-channel slice: turns the arbiter's grant into the channel's ready
// and masks the channel's data so the lanes can be OR-combined.
module rr_mux4_lane #(
  parameter int WIDTH = 8
) (
  input  logic             gnt,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic [WIDTH-1:0] data_m
);
  assign ready  = gnt;
  assign data_m = gnt ? data : '0;
endmodule

module rr_mux4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic [1:0]       sel;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic [1:0] ptr;
  beat_t      beat_q;
  logic       vld_q;

  logic                              load_en;
  logic [NUM_LANES-1:0]              gnt_oh;
  logic [1:0]                        gnt_idx;
  logic                              gnt_any;
  logic [NUM_LANES-1:0][WIDTH-1:0]   lane_data;
  logic [NUM_LANES-1:0][WIDTH-1:0]   lane_data_m;
  logic [WIDTH-1:0]                  mux_data;

  // Output stage can refill in the same cycle it drains.
  assign load_en = !vld_q || out_ready;

  // Rotating priority search starting at ptr. Reset forces no grant so
  // nothing is consumed from the sources while the block is held in reset.
  always_comb begin
    logic [1:0] idx;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = ptr + 2'(k);
      if (!gnt_any && in_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (rst || !load_en) gnt_any = 1'b0;
    if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lane_data[gi] = in_data[gi*WIDTH +: WIDTH];
      rr_mux4_lane #(.WIDTH(WIDTH)) u_lane (
        .gnt    (gnt_oh[gi]),
        .data   (lane_data[gi]),
        .ready  (in_ready[gi]),
        .data_m (lane_data_m[gi])
      );
    end
  endgenerate

  // Grant is one-hot, so an OR of the masked lanes selects the winner.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NUM_LANES; i++) mux_data = mux_data | lane_data_m[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      beat_q <= '0;
      ptr    <= '0;
    end else if (gnt_any) begin
      vld_q       <= 1'b1;
      beat_q.sel  <= gnt_idx;
      beat_q.data <= mux_data;
      ptr         <= gnt_idx + 2'd1;
    end else if (out_ready) begin
      // Drain with nothing to refill; held data/sel left as-is.
      vld_q <= 1'b0;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = beat_q.data;
  assign out_sel   = beat_q.sel;
endmodule

// File: tb/tb_rr_mux4.sv
// Scoreboard bench for rr_mux4: the driver predicts grants from a
// round-robin model and queues expected beats; a monitor checks the
// held output against the queue head and retires it on out_ready.
module tb_rr_mux4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;

  rr_mux4 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [9:0] sb[$];   // {sel, data}
  int  mptr = 0;
  bit  mv = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endfunction

  // One cycle: drive at negedge, compare the combinational ready and the
  // registered valid against the model, then advance the model.
  task automatic cycle(input logic r, input logic [3:0] v, input logic [4*W-1:0] d,
                       input logic ordy, output int g);
    logic [3:0] exp_rdy;
    int c;
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    g = -1;
    exp_rdy = 4'b0;
    if (!r && (!mv || ordy))
      for (int k = 0; k < 4; k++) begin
        c = (mptr + k) % 4;
        if (g < 0 && v[c]) g = c;
      end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (!r) check("out_valid", 32'(out_valid), 32'(mv));
    if (r) begin
      mv = 0; mptr = 0; sb.delete();
    end else if (g >= 0) begin
      sb.push_back({2'(g), d[g*W +: W]});
      mptr = (g + 1) % 4;
      mv = 1;
    end else if (mv && ordy) begin
      mv = 0;
    end
  endtask

  task automatic check_reset_state();
    @(posedge clk); #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_sel",   32'(out_sel),   32'd0);
  endtask

  // Monitor: held beat must match queue head every cycle it is valid.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk); #2;
      if (!rst && out_valid) begin
        if (sb.size() == 0) check("sb_unexpected_beat", 32'(out_valid), 32'd0);
        else begin
          e = sb[0];
          check("out_sel",  32'(out_sel),  32'(e[9:8]));
          check("out_data", 32'(out_data), 32'(e[7:0]));
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int g;
    logic [4*W-1:0] all4;
    bit         pv[4];
    logic [W-1:0] pd[4];
    logic [3:0] v;
    logic [4*W-1:0] d;
    all4 = {8'h43, 8'h32, 8'h21, 8'h10};
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;

    // Reset with all channels requesting
    cycle(1, 4'b1111, all4, 0, g);
    cycle(1, 4'b1111, all4, 0, g);
    check_reset_state();

    // Single source, then ptr wraps 3->0
    cycle(0, 4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 1, g);
    cycle(0, 4'b0101, {8'h00, 8'hA5, 8'h00, 8'h5A}, 1, g);
    cycle(0, 4'b0000, '0, 1, g);

    // All busy streaming
    for (int i = 0; i < 8; i++) cycle(0, 4'b1111, all4, 1, g);

    // Backpressure then release
    for (int i = 0; i < 3; i++) cycle(0, 4'b1111, all4, 0, g);
    for (int i = 0; i < 3; i++) cycle(0, 4'b1111, all4, 1, g);
    cycle(0, 4'b0000, '0, 1, g);
    cycle(0, 4'b0000, '0, 1, g);

    // Two-source fairness
    for (int i = 0; i < 8; i++) cycle(0, 4'b1001, all4, 1, g);
    cycle(0, 4'b0000, '0, 1, g);

    // Reset mid-operation with a held beat
    cycle(0, 4'b0100, all4, 1, g);
    cycle(0, 4'b0000, '0, 0, g);
    cycle(0, 4'b0000, '0, 0, g);
    cycle(1, 4'b1111, all4, 0, g);
    check_reset_state();
    cycle(0, 4'b1111, all4, 1, g);
    cycle(0, 4'b0000, '0, 1, g);

    // Random traffic obeying the source hold rule
    for (int c = 0; c < 4; c++) begin pv[c] = 0; pd[c] = '0; end
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 4; c++)
        if (!pv[c] && ($urandom_range(0, 1) == 1)) begin
          pv[c] = 1; pd[c] = W'($urandom);
        end
      for (int c = 0; c < 4; c++) begin
        v[c] = pv[c];
        d[c*W +: W] = pd[c];
      end
      cycle(0, v, d, ($urandom_range(0, 9) < 7), g);
      if (g >= 0) pv[g] = 0;
    end

    // Drain
    for (int i = 0; i < 4; i++) cycle(0, 4'b0000, '0, 1, g);
    @(negedge clk); #3;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
